cordic_arbiter: RTL and testbench
=================================

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 Parameter LATENCY, default 16: cycles from CORDIC input capture to valid CORDIC result, with clock enabled.
REQ-002 Parameter MAX_OUT, default 4: maximum outstanding operations per requester (1..15).
REQ-003 clk  in  1  single system clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low.
REQ-005 en  in  1  global enable; low freezes the arbiter and the CORDIC pipeline.
REQ-006 req0_valid / req1_valid  in  1 each  requester has an angle to issue.
REQ-007 req0_angle / req1_angle  in  32 each  IEEE-754 single angle operand.
REQ-008 req0_ready / req1_ready  out  1 each  grant; a transfer occurs when valid and ready are both high.
REQ-009 resp0_valid / resp1_valid  out  1 each  one-cycle result strobe to the owning requester; no backpressure.
REQ-010 resp_result  out  32  result word, shared by both requesters, qualified by respN_valid.
REQ-011 cordic_clk_en  out  1  drives the CORDIC clk_en.
REQ-012 cordic_angle  out  32  drives the CORDIC angle_float.
REQ-013 cordic_result  in  32  CORDIC result.
REQ-014 busy  out  1  high while any tag is valid.

Function
REQ-015 Requester N shall be eligible when reqN_valid=1 and its outstanding count < MAX_OUT.
REQ-016 With en=1, at most one ready shall assert per cycle, combinationally, granting an eligible requester.
REQ-017 If both requesters are eligible, the grant shall go to the one not granted last; last_grant shall update only on a transfer.
REQ-018 cordic_angle shall equal the granted requester's angle, else 0x00000000; cordic_clk_en shall equal en.
REQ-019 A LATENCY-deep tag shift register of {valid, id} shall advance only when en=1; on a transfer it loads {1, granted id}, otherwise {0, x}.
REQ-020 respN_valid shall equal en AND tag_out.valid AND (tag_out.id==N); resp_result shall equal cordic_result, combinationally.
REQ-021 A result shall be strobed exactly LATENCY enabled cycles after its transfer; en-low cycles extend this 1:1.
REQ-022 Outstanding count N shall increment on transfer and decrement on response; both in the same cycle leave it unchanged; it shall never exceed MAX_OUT or wrap below 0.
REQ-023 Responses shall return in issue order, and interleaved issues shall route to the correct owner.
REQ-024 With en=0, both ready, both resp_valid and all state updates shall be held low or frozen.

Reset
REQ-025 On rst=0, immediately and asynchronously, all tags, both counters and busy shall clear, and last_grant shall become 1 (requester 0 wins first).
REQ-026 While rst=0, ready, resp_valid and busy shall be 0; cordic_angle shall be 0x00000000.
REQ-027 Reset mid-operation shall discard in-flight results; no response strobe for pre-reset issues shall occur after release.

Configuration
REQ-028 With CORDIC_ARB_FIXED_PRIORITY_EN defined, requester 0 shall always win when both are eligible and last_grant is unused.
REQ-029 Without CORDIC_ARB_FIXED_PRIORITY_EN, round-robin per REQ-017 applies; all other behaviour is identical.

Verification
REQ-030 Single issue: req0 angle 0x3F7CAC08 at cycle 0, en=1 -> resp0_valid only at cycle 16, resp_result = cordic_result, resp1_valid stays 0.
REQ-031 Contention: both valid continuously -> grants alternate 0,1,0,1 (fixed-priority build: 0 until its count reaches 4), responses alternate to the matching owner.
REQ-032 Credit limit: req0 valid only, MAX_OUT=4 -> exactly 4 transfers, ready0 low until the first response; a new transfer is allowed in that same response cycle.
REQ-033 Stall: drop en for 5 cycles after issue at cycle 0 -> response at cycle 21, no ready during the stall, cordic_clk_en = 0 for 5 cycles.
REQ-034 Reset mid-flight: 3 issues, then rst low at cycle 8 for 2 cycles -> no responses afterwards, busy = 0, next grant goes to requester 0.
REQ-035 Angle 0xBD8F5C29 from req1 while req0 is idle -> cordic_angle = 0xBD8F5C29 in the transfer cycle, resp1_valid at +16.

Source files
------------

// File: rtl/cordic_arbiter.sv
// Two-requester arbiter in front of a fixed-latency CORDIC pipeline: per-requester
// credit limiting, tag tracking and response routing. Optional macro: CORDIC_ARB_FIXED_PRIORITY_EN.
module cordic_arbiter #(
   parameter int unsigned LATENCY = 16,
   parameter int unsigned MAX_OUT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        req0_valid,
   input  logic [31:0] req0_angle,
   input  logic        req1_valid,
   input  logic [31:0] req1_angle,
   output logic        req0_ready,
   output logic        req1_ready,
   output logic        resp0_valid,
   output logic        resp1_valid,
   output logic [31:0] resp_result,
   output logic        cordic_clk_en,
   output logic [31:0] cordic_angle,
   input  logic [31:0] cordic_result,
   output logic        busy
);

   localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

   logic [LATENCY-1:0] tag_valid;
   logic [LATENCY-1:0] tag_id;
   logic [CNT_W-1:0]   cnt0;
   logic [CNT_W-1:0]   cnt1;
   logic               elig0;
   logic               elig1;
   logic               gnt0;
   logic               gnt1;
   logic               xfer;
`ifndef CORDIC_ARB_FIXED_PRIORITY_EN
   logic               last_grant;
`endif

   // Response routing from the tag leaving the pipeline
   always_comb begin
      resp0_valid = en & tag_valid[LATENCY-1] & ~tag_id[LATENCY-1];
      resp1_valid = en & tag_valid[LATENCY-1] &  tag_id[LATENCY-1];
      resp_result = cordic_result;
      busy        = |tag_valid;
   end

   // A response in this cycle frees a credit for a same-cycle transfer
   always_comb begin
      elig0 = req0_valid & ((cnt0 < CNT_W'(MAX_OUT)) | resp0_valid);
      elig1 = req1_valid & ((cnt1 < CNT_W'(MAX_OUT)) | resp1_valid);
   end

   // Grant selection
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n && en) begin
         if (elig0 && elig1) begin
`ifdef CORDIC_ARB_FIXED_PRIORITY_EN
            gnt0 = 1'b1;
`else
            gnt0 = last_grant;
            gnt1 = ~last_grant;
`endif
         end else begin
            gnt0 = elig0;
            gnt1 = elig1;
         end
      end
      xfer = gnt0 | gnt1;
   end

   always_comb begin
      req0_ready    = gnt0;
      req1_ready    = gnt1;
      cordic_clk_en = en;
      cordic_angle  = 32'h0000_0000;
      if (gnt0) begin
         cordic_angle = req0_angle;
      end else if (gnt1) begin
         cordic_angle = req1_angle;
      end
   end

   // Tag pipeline mirrors the CORDIC pipeline depth and advances with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_valid <= '0;
         tag_id    <= '0;
      end else if (en) begin
         for (int i = LATENCY - 1; i > 0; i--) begin
            tag_valid[i] <= tag_valid[i-1];
            tag_id[i]    <= tag_id[i-1];
         end
         tag_valid[0] <= xfer;
         tag_id[0]    <= gnt1;
      end
   end

   // Outstanding-operation credit counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else if (en) begin
         if (gnt0 && !resp0_valid) begin
            cnt0 <= cnt0 + CNT_W'(1);
         end else if (!gnt0 && resp0_valid && cnt0 != '0) begin
            cnt0 <= cnt0 - CNT_W'(1);
         end
         if (gnt1 && !resp1_valid) begin
            cnt1 <= cnt1 + CNT_W'(1);
         end else if (!gnt1 && resp1_valid && cnt1 != '0) begin
            cnt1 <= cnt1 - CNT_W'(1);
         end
      end
   end

`ifndef CORDIC_ARB_FIXED_PRIORITY_EN
   // Reset value 1 lets requester 0 win the first contended cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
      end else if (en && xfer) begin
         last_grant <= gnt1;
      end
   end
`endif

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter with a behavioural delay-line CORDIC model.
module tb_cordic_arbiter;

   localparam int unsigned LAT = 16;
   localparam int unsigned MOUT = 4;
   localparam logic [31:0] KEY = 32'h5A5A_A5A5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_angle, req1_angle;
   logic        req0_ready, req1_ready;
   logic        resp0_valid, resp1_valid;
   logic [31:0] resp_result;
   logic        cordic_clk_en;
   logic [31:0] cordic_angle;
   logic [31:0] cordic_result;
   logic        busy;

   typedef struct {
      logic        id;
      logic [31:0] res;
      int unsigned due;
   } ent_t;

   ent_t        q[$];
   int unsigned total = 0;
   int unsigned bad = 0;
   int unsigned ecnt = 0;
   int unsigned mc0 = 0, mc1 = 0;
   logic        mlast = 1'b1;
   logic [31:0] pipe [LAT];

   always #5 clk = ~clk;

   cordic_arbiter #(.LATENCY(LAT), .MAX_OUT(MOUT)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .req0_valid(req0_valid), .req0_angle(req0_angle),
      .req1_valid(req1_valid), .req1_angle(req1_angle),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
      .resp_result(resp_result), .cordic_clk_en(cordic_clk_en),
      .cordic_angle(cordic_angle), .cordic_result(cordic_result),
      .busy(busy)
   );

   // Stand-in CORDIC: a clock-enabled delay line with a recognisable transform
   initial for (int i = 0; i < int'(LAT); i++) pipe[i] = 32'h0;
   always @(posedge clk) begin
      if (cordic_clk_en) begin
         for (int i = int'(LAT) - 1; i > 0; i--) pipe[i] <= pipe[i-1];
         pipe[0] <= cordic_angle;
      end
   end
   assign cordic_result = pipe[LAT-1] ^ KEY;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: sample and check at negedge, update the model, return after posedge
   task automatic cyc();
      logic r0, r1, e0, e1, g0, g1;
      logic [31:0] ea;
      @(negedge clk);
      if (!rst_n) begin
         q.delete();
         mc0 = 0; mc1 = 0; mlast = 1'b1;
         chk("rst_ready0", 32'(req0_ready), 32'd0);
         chk("rst_ready1", 32'(req1_ready), 32'd0);
         chk("rst_resp0", 32'(resp0_valid), 32'd0);
         chk("rst_resp1", 32'(resp1_valid), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_angle", cordic_angle, 32'd0);
      end else begin
         r0 = 1'b0; r1 = 1'b0;
         if (en && q.size() > 0) begin
            if (q[0].due == ecnt) begin
               r0 = ~q[0].id;
               r1 = q[0].id;
            end
         end
         e0 = req0_valid && (mc0 < MOUT || r0);
         e1 = req1_valid && (mc1 < MOUT || r1);
         g0 = 1'b0; g1 = 1'b0;
         if (en) begin
            if (e0 && e1) begin
`ifdef CORDIC_ARB_FIXED_PRIORITY_EN
               g0 = 1'b1;
`else
               g0 = mlast; g1 = ~mlast;
`endif
            end else begin
               g0 = e0; g1 = e1;
            end
         end
         ea = g0 ? req0_angle : (g1 ? req1_angle : 32'h0);
         chk("ready0", 32'(req0_ready), 32'(g0));
         chk("ready1", 32'(req1_ready), 32'(g1));
         chk("resp0", 32'(resp0_valid), 32'(r0));
         chk("resp1", 32'(resp1_valid), 32'(r1));
         chk("busy", 32'(busy), 32'(q.size() != 0));
         chk("cordic_angle", cordic_angle, ea);
         chk("clk_en", 32'(cordic_clk_en), 32'(en));
         chk("resp_pass", resp_result, cordic_result);
         if (r0 || r1) begin
            chk("resp_result", resp_result, q[0].res);
            void'(q.pop_front());
         end
         if (g0) q.push_back('{id: 1'b0, res: req0_angle ^ KEY, due: ecnt + LAT});
         if (g1) q.push_back('{id: 1'b1, res: req1_angle ^ KEY, due: ecnt + LAT});
         if (g0 && !r0) mc0++;
         if (!g0 && r0) mc0--;
         if (g1 && !r1) mc1++;
         if (!g1 && r1) mc1--;
         if (g0 || g1) mlast = g1;
         if (en) ecnt++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      int nresp;
      rst_n = 1'b0; en = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_angle = 32'h0; req1_angle = 32'h0;
      run(3);
      rst_n = 1'b1; en = 1'b1;
      run(2);

      // Single issue from requester 0
      req0_valid = 1'b1; req0_angle = 32'h3F7C_AC08;
      cyc();
      req0_valid = 1'b0;
      run(20);

      // Requester 1 alone
      req1_valid = 1'b1; req1_angle = 32'hBD8F_5C29;
      cyc();
      req1_valid = 1'b0;
      run(20);

      // Contention with changing angles, runs into both credit limits
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         req0_angle = $urandom; req1_angle = $urandom;
         cyc();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      run(20);

      // Credit limit on requester 0 alone
      req0_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         req0_angle = $urandom;
         cyc();
      end
      req0_valid = 1'b0;
      run(20);

      // Stall: en low five cycles after an issue, requester 1 waiting meanwhile
      req0_valid = 1'b1; req0_angle = 32'h4049_0FDB;
      cyc();
      req0_valid = 1'b0; req1_valid = 1'b1; req1_angle = 32'h3F00_0000;
      en = 1'b0;
      run(5);
      en = 1'b1; req1_valid = 1'b0;
      run(25);

      // Reset mid-flight discards in-flight results
      req0_valid = 1'b1; req0_angle = 32'h1111_1111; cyc();
      req0_valid = 1'b0; req1_valid = 1'b1; req1_angle = 32'h2222_2222; cyc();
      req1_valid = 1'b0; req0_valid = 1'b1; req0_angle = 32'h3333_3333; cyc();
      req0_valid = 1'b0;
      run(5);
      rst_n = 1'b0;
      run(2);
      rst_n = 1'b1;
      nresp = 0;
      for (int i = 0; i < 25; i++) begin
         cyc();
         if (resp0_valid || resp1_valid) nresp++;
      end
      chk("post_rst_no_resp", 32'(nresp), 32'd0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_angle = 32'h4444_4444; req1_angle = 32'h5555_5555;
      @(negedge clk);
      chk("post_rst_first_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
      @(posedge clk); #1;
      mc0 = 1; mlast = 1'b0;
      q.push_back('{id: 1'b0, res: 32'h4444_4444 ^ KEY, due: ecnt + LAT});
      ecnt++;
      req0_valid = 1'b0; req1_valid = 1'b0;
      run(20);

      // Randomised traffic with enable gaps
      for (int i = 0; i < 300; i++) begin
         en = ($urandom_range(9) != 0);
         req0_valid = $urandom_range(1); req1_valid = $urandom_range(1);
         req0_angle = $urandom; req1_angle = $urandom;
         cyc();
      end
      en = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
      run(20);
      chk("final_drain", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
